// File: rtl/des_perm_engine.sv
// des_perm_engine: serialised DES initial / final permutation engine with valid-ready handshake
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake; mode (0=IP, 1=FP) and halves sampled on accept
//   left_half, right_half    combined word = {left_half, right_half}
//   swap_halves              only with DES_PERM_HALF_SWAP_EN: 1 -> combined = {right_half, left_half}
//   out_valid / out_ready    output handshake; out_data held stable while out_valid
//   busy                     high while the permutation is being produced
// Optional feature macro: DES_PERM_HALF_SWAP_EN
module des_perm_engine #(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [31:0] left_half,
  input  logic [31:0] right_half,
`ifdef DES_PERM_HALF_SWAP_EN
  input  logic        swap_halves,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);
  localparam int NUM_STEPS = 64 / BITS_PER_CYCLE;
  localparam int CW = NUM_STEPS > 1 ? $clog2(NUM_STEPS) : 1;
  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8 &&
      BITS_PER_CYCLE != 16 && BITS_PER_CYCLE != 32 && BITS_PER_CYCLE != 64) begin : g_bad_bpc
    $error("des_perm_engine: BITS_PER_CYCLE must be a power of two between 1 and 64");
  end
  localparam logic [6:0] IP_T [64] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };
  localparam logic [6:0] FP_T [64] = '{
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_comb, r_out, w_perm, w_comb_in;
  logic          r_mode, w_last, w_accept;
`ifdef DES_PERM_HALF_SWAP_EN
  assign w_comb_in = swap_halves ? {right_half, left_half} : {left_half, right_half};
`else
  assign w_comb_in = {left_half, right_half};
`endif
  assign w_last   = r_cnt == CW'(NUM_STEPS - 1);
  assign w_accept = r_state == S_IDLE && in_valid;
  assign out_data = r_out;
  // Tables are 1-based; the chunk for the current step is sliced out of the full permuted word.
  always_comb begin
    w_perm = '0;
    for (int i = 0; i < 64; i++)
      w_perm[i] = r_comb[6'((r_mode ? FP_T[i] : IP_T[i]) - 7'd1)];
  end
  always_comb begin
    w_next    = r_state;
    in_ready  = r_state == S_IDLE;
    busy      = r_state == S_BUSY;
    out_valid = r_state == S_DONE;
    unique case (r_state)
      S_IDLE:  w_next = in_valid ? S_BUSY : S_IDLE;
      S_BUSY:  w_next = w_last ? S_DONE : S_BUSY;
      S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_comb  <= '0;
      r_mode  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_comb <= w_comb_in;
        r_mode <= mode;
        r_cnt  <= '0;
      end
      if (r_state == S_BUSY) begin
        r_out[r_cnt*BITS_PER_CYCLE +: BITS_PER_CYCLE] <= w_perm[r_cnt*BITS_PER_CYCLE +: BITS_PER_CYCLE];
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_des_perm_engine.sv
// tb_des_perm_engine: table-driven scoreboard bench running BPC = 1, 8 and 64 engines in lockstep
module tb_des_perm_engine;
  logic        clk, rst, in_valid, mode, out_ready;
  logic [31:0] left_half, right_half;
  logic [2:0]  rdy, ov, bz;
  logic [63:0] od [3];
`ifdef DES_PERM_HALF_SWAP_EN
  logic        swap;
`endif
  int n_vec = 0;
  int n_err = 0;
  int steps [3] = '{64, 8, 1};
  logic [63:0] q [$];
  typedef struct {
    logic        m;
    logic [31:0] l;
    logic [31:0] r;
    logic        sw;
    logic [63:0] e;
  } vec_t;
  vec_t vt [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  des_perm_engine #(.BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .mode(mode),
    .left_half(left_half), .right_half(right_half),
`ifdef DES_PERM_HALF_SWAP_EN
    .swap_halves(swap),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));
  des_perm_engine #(.BITS_PER_CYCLE(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .mode(mode),
    .left_half(left_half), .right_half(right_half),
`ifdef DES_PERM_HALF_SWAP_EN
    .swap_halves(swap),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));
  des_perm_engine #(.BITS_PER_CYCLE(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .mode(mode),
    .left_half(left_half), .right_half(right_half),
`ifdef DES_PERM_HALF_SWAP_EN
    .swap_halves(swap),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));

  // Reference built from the arithmetic structure of the DES tables rather than the tables themselves.
  function automatic logic [63:0] perm(input logic m, input logic [63:0] x);
    logic [63:0] y;
    int r, c, t;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      r = i / 8;
      c = i % 8;
      t = m ? (c % 2 == 0 ? 40 : 8) + 8 * (c / 2) - r : (r < 4 ? 58 + 2 * r : 57 + 2 * (r - 4)) - 8 * c;
      y[i] = x[t-1];
    end
    return y;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic run(input vec_t v, input int hold);
    int lat [3];
    logic [63:0] e;
    @(negedge clk);
    for (int k = 0; k < 100 && rdy != 3'b111; k++) @(negedge clk);
    chk("in_ready_before_accept", 64'(rdy), 64'h7);
    in_valid = 1'b1;
    mode = v.m;
    left_half = v.l;
    right_half = v.r;
`ifdef DES_PERM_HALF_SWAP_EN
    swap = v.sw;
`endif
    q.push_back(v.e);
    @(posedge clk);
    #1;
    lat = '{0, 0, 0};
    for (int k = 1; k <= 70 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); k++) begin
      in_valid = 1'($urandom_range(0, 1));
      mode = ~v.m;
      left_half = $urandom;
      right_half = $urandom;
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) if (ov[j] && lat[j] == 0) lat[j] = k;
    end
    e = q.pop_front();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("latency_bpc%0d", 64 / steps[j]), 64'(lat[j]), 64'(steps[j]));
      chk($sformatf("out_data_bpc%0d", 64 / steps[j]), od[j], e);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      left_half = $urandom;
      right_half = $urandom;
      @(posedge clk);
      #1;
      chk("hold_ready_valid", {58'h0, rdy, ov}, {58'h0, 3'b000, 3'b111});
      for (int j = 0; j < 3; j++) chk("hold_out_data", od[j], e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("after_release", {58'h0, rdy, ov}, {58'h0, 3'b111, 3'b000});
  endtask

  initial begin
    logic [63:0] x, ipv;
    rst = 1'b1;
    in_valid = 1'b0;
    mode = 1'b0;
    out_ready = 1'b0;
    left_half = '0;
    right_half = '0;
`ifdef DES_PERM_HALF_SWAP_EN
    swap = 1'b0;
`endif
    ipv = perm(1'b0, 64'h0123_4567_89AB_CDEF);
    vt.push_back('{1'b1, 32'h0, 32'h0000_0080, 1'b0, 64'h2});
    vt.push_back('{1'b0, 32'h0200_0000, 32'h0, 1'b0, 64'h1});
    vt.push_back('{1'b1, 32'h0000_0080, 32'h0, 1'b0, 64'h1});
    vt.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    vt.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    vt.push_back('{1'b0, 32'h0123_4567, 32'h89AB_CDEF, 1'b0, ipv});
    vt.push_back('{1'b1, ipv[63:32], ipv[31:0], 1'b0, 64'h0123_4567_89AB_CDEF});
    vt.push_back('{1'b1, 32'h0, 32'h0, 1'b0, 64'h0});
    for (int k = 0; k < 4; k++) begin
      x = {$urandom, $urandom};
      vt.push_back('{1'(k % 2), x[63:32], x[31:0], 1'b0, perm(1'(k % 2), x)});
    end
`ifdef DES_PERM_HALF_SWAP_EN
    vt.push_back('{1'b1, 32'h0000_0080, 32'h0, 1'b1, 64'h2});
    x = {$urandom, $urandom};
    vt.push_back('{1'b0, x[63:32], x[31:0], 1'b1, perm(1'b0, {x[31:0], x[63:32]})});
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(ov), 64'h0);
    chk("reset_busy", 64'(bz), 64'h0);
    for (int j = 0; j < 3; j++) chk("reset_out_data", od[j], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 64'(rdy), 64'h7);
    foreach (vt[i]) run(vt[i], i == 2 ? 10 : 0);
    @(negedge clk);
    in_valid = 1'b1;
    mode = 1'b0;
    left_half = 32'hDEAD_BEEF;
    right_half = 32'h1234_5678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_midreset", 64'(bz), 64'h3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", 64'(ov), 64'h0);
    chk("midreset_busy", 64'(bz), 64'h0);
    for (int j = 0; j < 3; j++) chk("midreset_out_data", od[j], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_midreset", 64'(rdy), 64'h7);
    run(vt[6], 0);
    run(vt[5], 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/des_perm_engine.md
Name: des_perm_engine

Overview:
- Parametrised, handshaked DES permutation engine; successor to the single-mode combinational final-permutation block.
- Performs the Initial Permutation (IP) or its inverse (IP^-1 / FP), selected per transaction.
- Serialised over a configurable number of cycles to trade area for latency.
- Sits between the data-path front end and the round core (IP), and between the round core and the output (FP).

Parameters:
- BITS_PER_CYCLE, 8, output bits produced per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64. Any other value is an elaboration error.
- NUM_STEPS, 64/BITS_PER_CYCLE, derived localparam; not user-overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine can accept a word.
- mode  in  1  0 = IP, 1 = FP (IP^-1). Sampled on accept.
- left_half  in  32  forms combined[63:32].
- right_half  in  32  forms combined[31:0].
- out_valid  out  1  out_data holds a complete result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  64  permuted word.
- busy  out  1  high while in BUSY state.

Behaviour:
- Bit convention: out_data[i] = combined[T[i]-1], for i = 0..63, where T[k] is the k-th entry of the 1-based DES table as listed.
- FP table T (k = 0..63): 40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25.
- IP table: the standard DES IP table (58,50,42,34,26,18,10,2, 60,52,... ,7), same index convention. IP then FP is the identity.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: step counter runs.
  - DONE: out_valid=1.
- Transitions:
  - IDLE -> BUSY on in_valid && in_ready. Latch combined, mode, and counter=0.
  - BUSY: each cycle, write out_data[cnt*BPC +: BPC] from the table; cnt++. After step NUM_STEPS-1, go to DONE.
  - DONE -> IDLE on out_ready.
  - out_data is held stable throughout DONE until out_ready.
- Latency: out_valid asserts exactly NUM_STEPS cycles after the accept edge. BPC=64 gives 1 cycle.
- Throughput: one word per NUM_STEPS+2 cycles at best. No accept is possible in BUSY or DONE (in_ready=0).
- Input changes, including mode, during BUSY/DONE: ignored.
- Reset, at any time including mid-operation:
  - State goes to IDLE; cnt=0.
  - out_valid=0, out_data=64'h0, busy=0.
  - In-flight word is discarded.
  - in_ready=1 in the cycle after reset deasserts.
- Table lookup indices are 7-bit; subtract 1 before indexing. The index never exceeds 63.

Optional Feature:
- Macro: DES_PERM_HALF_SWAP_EN.
- Defined:
  - Adds input port swap_halves (1 bit), sampled on accept.
  - When 1, combined = {right_half, left_half} before permutation (DES pre-output R16L16 swap).
- Undefined:
  - Port absent; combined = {left_half, right_half} always.

Test Plan:
- FP, left=32'h0000_0080... correction: left=0, right=32'h0000_0080 (combined bit 7) -> out_data=64'h0000_0000_0000_0002, out_valid NUM_STEPS cycles after accept.
- IP, left=32'h0200_0000 (combined bit 57) -> out_data=64'h0000_0000_0000_0001.
- FP, left=32'h0000_0080 (combined bit 39) -> out_data=64'h1. Then all-ones input in either mode -> 64'hFFFF_FFFF_FFFF_FFFF.
- Round trip: IP of {32'h0123_4567, 32'h89AB_CDEF}, feed the result back as FP -> 64'h0123_4567_89AB_CDEF.
- Repeat the round trip for BPC = 1, 8 and 64; latencies must be 64, 8 and 1 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, in_valid pulses ignored.
- Reset mid-BUSY at cnt=3 -> next cycle out_valid=0 and out_data=0; the next transaction produces a correct result.
- With DES_PERM_HALF_SWAP_EN and swap_halves=1: left=32'h0000_0080, right=0, FP -> 64'h2.
